// File: rtl/uart_pkg.sv
// Shared UART types and constants for the TX engine and the RX engine.
package uart_pkg;

    localparam int unsigned UART_MIN_DATA_BITS = 5;
    localparam logic        UART_START_BIT     = 1'b0;
    localparam logic        UART_STOP_BIT      = 1'b1;

    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } uart_parity_e;

    typedef enum logic [1:0] {
        STOP_1     = 2'd0,
        STOP_1P5   = 2'd1,
        STOP_2     = 2'd2,
        STOP_2_ALT = 2'd3
    } uart_stop_e;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK      = 3'd5,
        ST_BREAK_MARK = 3'd6
    } uart_tx_state_e;

    // Per-frame format captured at the handshake.
    typedef struct packed {
        logic [3:0]   data_bits;
        uart_parity_e parity;
        logic         par_bit;
        uart_stop_e   stop;
    } uart_frame_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period down-counter: loaded with (bit length - 1), done while the count is 0.
module uart_bit_timer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt_q;

    // Saturates at zero; a load always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= value;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    assign done = (cnt_q == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// Self-timed UART transmitter: frame capture, shifter, bit timer and sequencing FSM.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int unsigned MAX_DATA_BITS = 9,
    parameter int unsigned BAUD_CNT_W    = 32,
    parameter bit          MSB_FIRST     = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [BAUD_CNT_W-1:0]    baud_div,
    input  logic [3:0]               cfg_data_bits,
    input  logic [2:0]               cfg_parity,
    input  logic [1:0]               cfg_stop,
    input  logic                     cfg_break,
    input  logic                     tx_valid,
    input  logic [MAX_DATA_BITS-1:0] tx_data,
    output logic                     tx_ready,
    output logic                     tx,
    output logic                     tx_busy,
    output logic                     tx_done,
    output logic                     cfg_err
);

    localparam int unsigned DW = MAX_DATA_BITS;
    localparam int unsigned BW = BAUD_CNT_W;

    uart_tx_state_e  state_q, state_d;
    uart_frame_t     frame_q, frame_d;
    logic [DW-1:0]   shift_q, shift_d;
    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic            stop_last_q, stop_last_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic            tx_q, tx_d;
    logic            busy_q;
    logic            run_q;

    logic            tmr_load, tmr_done;
    logic [BW-1:0]   tmr_value;
    logic [BW-1:0]   full_m1_live, full_m1_q, half_m1_q, half_q;
    logic [DW-1:0]   data_masked;
    logic            par_calc;
    logic            cfg_err_raw;
    logic            xfer;

    uart_bit_timer #(.W(BW)) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (tmr_value),
        .en    (state_q != ST_IDLE),
        .done  (tmr_done)
    );

    // Bit lengths minus one; a divisor of 0 behaves as 1, the half bit is at least 1 cycle.
    assign half_q       = baud_q >> 1;
    assign full_m1_live = (baud_div == '0) ? '0 : baud_div - BW'(1);
    assign full_m1_q    = (baud_q == '0) ? '0 : baud_q - BW'(1);
    assign half_m1_q    = (half_q == '0) ? '0 : half_q - BW'(1);

    assign cfg_err_raw = (cfg_data_bits < 4'(UART_MIN_DATA_BITS)) ||
                         (cfg_data_bits > 4'(MAX_DATA_BITS)) ||
                         (cfg_parity > 3'd4);

    assign tx_done  = (state_q == ST_STOP) && tmr_done && stop_last_q;
    assign tx_ready = run_q && ((state_q == ST_IDLE) || tx_done) && !cfg_break && !cfg_err_raw;
    assign cfg_err  = run_q && cfg_err_raw;
    assign xfer     = tx_valid && tx_ready;
    assign tx       = tx_q;
    assign tx_busy  = busy_q;

    // Parity over the live payload, only the configured number of bits.
    always_comb begin
        data_masked = '0;
        par_calc    = 1'b0;
        for (int i = 0; i < int'(DW); i++) begin
            if (4'(i) < cfg_data_bits) data_masked[i] = tx_data[i];
        end
        case (uart_parity_e'(cfg_parity))
            PAR_EVEN: par_calc = ^data_masked;
            PAR_ODD:  par_calc = ~(^data_masked);
            PAR_MARK: par_calc = 1'b1;
            default:  par_calc = 1'b0;
        endcase
    end

    // Next-state, frame capture, timer control and next line level.
    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        stop_last_d = stop_last_q;
        baud_d      = baud_q;
        tmr_load    = 1'b0;
        tmr_value   = full_m1_q;
        tx_d        = UART_STOP_BIT;

        if (xfer) begin
            frame_d.data_bits = cfg_data_bits;
            frame_d.parity    = uart_parity_e'(cfg_parity);
            frame_d.par_bit   = par_calc;
            frame_d.stop      = uart_stop_e'(cfg_stop);
            baud_d            = baud_div;
            shift_d           = MSB_FIRST ? DW'(tx_data << (4'(DW) - cfg_data_bits)) : tx_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (run_q && cfg_break) begin
                    state_d = ST_BREAK;
                end else if (xfer) begin
                    state_d   = ST_START;
                    tmr_load  = 1'b1;
                    tmr_value = full_m1_live;
                end
            end
            ST_START: begin
                if (tmr_done) begin
                    state_d   = ST_DATA;
                    tmr_load  = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (tmr_done) begin
                    tmr_load = 1'b1;
                    if (bit_cnt_q == frame_q.data_bits - 4'd1) begin
                        if (frame_q.parity != PAR_NONE) begin
                            state_d = ST_PARITY;
                        end else begin
                            state_d     = ST_STOP;
                            stop_last_d = (frame_q.stop == STOP_1);
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        shift_d   = MSB_FIRST ? (shift_q << 1) : (shift_q >> 1);
                    end
                end
            end
            ST_PARITY: begin
                if (tmr_done) begin
                    state_d     = ST_STOP;
                    tmr_load    = 1'b1;
                    stop_last_d = (frame_q.stop == STOP_1);
                end
            end
            ST_STOP: begin
                if (tmr_done) begin
                    if (stop_last_q) begin
                        if (xfer) begin
                            state_d   = ST_START;
                            tmr_load  = 1'b1;
                            tmr_value = full_m1_live;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        // Second stop segment: half bit for 1.5, full bit for 2.
                        stop_last_d = 1'b1;
                        tmr_load    = 1'b1;
                        tmr_value   = (frame_q.stop == STOP_1P5) ? half_m1_q : full_m1_q;
                    end
                end
            end
            ST_BREAK: begin
                if (!cfg_break) begin
                    state_d   = ST_BREAK_MARK;
                    tmr_load  = 1'b1;
                    tmr_value = full_m1_live;
                end
            end
            ST_BREAK_MARK: begin
                if (tmr_done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        case (state_d)
            ST_START:  tx_d = UART_START_BIT;
            ST_DATA:   tx_d = MSB_FIRST ? shift_d[DW-1] : shift_d[0];
            ST_PARITY: tx_d = frame_d.par_bit;
            ST_BREAK:  tx_d = 1'b0;
            default:   tx_d = UART_STOP_BIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            frame_q     <= '{data_bits: 4'd0, parity: PAR_NONE, par_bit: 1'b0, stop: STOP_1};
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            stop_last_q <= 1'b0;
            baud_q      <= '0;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            run_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stop_last_q <= stop_last_d;
            baud_q      <= baud_d;
            tx_q        <= tx_d;
            busy_q      <= (state_d != ST_IDLE);
            run_q       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench for uart_tx_engine with hand-computed line waveforms.
module tb_uart_tx_engine;

    logic        clk;
    logic        rst_n;
    logic [31:0] baud_div;
    logic [3:0]  cfg_data_bits;
    logic [2:0]  cfg_parity;
    logic [1:0]  cfg_stop;
    logic        cfg_break;
    logic        tx_valid;
    logic [8:0]  tx_data;
    logic        tx_ready;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;
    logic        cfg_err;

    int checks = 0;
    int errors = 0;

    uart_tx_engine #(
        .MAX_DATA_BITS (9),
        .BAUD_CNT_W    (32),
        .MSB_FIRST     (1'b0)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .baud_div      (baud_div),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop      (cfg_stop),
        .cfg_break     (cfg_break),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .tx            (tx),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .cfg_err       (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int baud, input int nbits, input int par, input int stop);
        baud_div      = 32'(baud);
        cfg_data_bits = 4'(nbits);
        cfg_parity    = 3'(par);
        cfg_stop      = 2'(stop);
    endtask

    // Waits (bounded) for tx_ready, then performs the handshake edge.
    task automatic start_frame(input string name, input logic [8:0] d, input bit keep_valid);
        int n;
        n        = 0;
        tx_valid = 1'b1;
        tx_data  = d;
        while (!tx_ready && n < 200) begin
            tick();
            n++;
        end
        chk({name, " ready_wait"}, 32'(tx_ready), 32'd1);
        tick();
        if (!keep_valid) tx_valid = 1'b0;
    endtask

    // seq holds the frame bits left-aligned, first bit at seq[15]; last bit lasts last_len cycles.
    task automatic check_frame(input string name, input logic [15:0] seq, input int nb,
                               input int baud, input int last_len, input logic ready_at_done);
        int   len;
        logic last;
        for (int i = 0; i < nb; i++) begin
            len = (i == nb - 1) ? last_len : baud;
            for (int j = 0; j < len; j++) begin
                last = (i == nb - 1) && (j == len - 1);
                chk({name, " tx"},    32'(tx),       32'(seq[15 - i]));
                chk({name, " done"},  32'(tx_done),  32'(last));
                chk({name, " busy"},  32'(tx_busy),  32'd1);
                chk({name, " ready"}, 32'(tx_ready), 32'(last & ready_at_done));
                tick();
            end
        end
    endtask

    task automatic check_idle(input string name);
        chk({name, " idle_tx"},   32'(tx),      32'd1);
        chk({name, " idle_busy"}, 32'(tx_busy), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_break = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        set_cfg(4, 8, 0, 0);

        // Reset values
        #12;
        chk("rst tx",    32'(tx),       32'd1);
        chk("rst ready", 32'(tx_ready), 32'd0);
        chk("rst busy",  32'(tx_busy),  32'd0);
        chk("rst done",  32'(tx_done),  32'd0);
        chk("rst err",   32'(cfg_err),  32'd0);
        #11;
        rst_n = 1'b1;
        tick();
        chk("post_rst ready", 32'(tx_ready), 32'd1);

        // 1: 8N1 0xA5, 4 cycles per bit, 40-cycle frame
        set_cfg(4, 8, 0, 0);
        start_frame("t1", 9'h0A5, 1'b0);
        check_frame("t1", 16'b0101001011_000000, 10, 4, 4, 1'b1);
        check_idle("t1");

        // 2: 7E2 0x41 at 3 cycles per bit, parity 0, 33-cycle frame
        set_cfg(3, 7, 1, 2);
        start_frame("t2e", 9'h041, 1'b0);
        check_frame("t2e", 16'b01000001011_00000, 11, 3, 3, 1'b1);
        check_idle("t2e");

        // 2b: odd parity; config changed mid-frame must not disturb the frame
        set_cfg(3, 7, 2, 2);
        start_frame("t2o", 9'h041, 1'b0);
        set_cfg(7, 8, 0, 0);
        check_frame("t2o", 16'b01000001111_00000, 11, 3, 3, 1'b1);
        check_idle("t2o");

        // 3: 5 bits, mark parity, 1.5 stop, 0x1F: last stop segment 2 cycles, 34 total
        set_cfg(4, 5, 3, 1);
        start_frame("t3", 9'h01F, 1'b0);
        check_frame("t3", 16'b011111111_0000000, 9, 4, 2, 1'b1);
        check_idle("t3");

        // 4: back-to-back 0x55 then 0xAA with tx_valid held, no idle gap
        set_cfg(4, 8, 0, 0);
        start_frame("t4a", 9'h055, 1'b1);
        tx_data = 9'h0AA;
        check_frame("t4a", 16'b0101010101_000000, 10, 4, 4, 1'b1);
        tx_valid = 1'b0;
        check_frame("t4b", 16'b0010101011_000000, 10, 4, 4, 1'b1);
        check_idle("t4b");

        // 5: break raised mid-frame: frame completes, then break, then one bit of mark
        set_cfg(2, 8, 0, 0);
        start_frame("t5", 9'h00F, 1'b0);
        cfg_break = 1'b1;
        check_frame("t5", 16'b0111100001_000000, 10, 2, 2, 1'b0);
        chk("t5 gap tx",    32'(tx),       32'd1);
        chk("t5 gap ready", 32'(tx_ready), 32'd0);
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("t5 brk tx",    32'(tx),       32'd0);
            chk("t5 brk busy",  32'(tx_busy),  32'd1);
            chk("t5 brk ready", 32'(tx_ready), 32'd0);
            tick();
        end
        cfg_break = 1'b0;
        chk("t5 brk_fall tx", 32'(tx), 32'd0);
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t5 mark tx",    32'(tx),       32'd1);
            chk("t5 mark busy",  32'(tx_busy),  32'd1);
            chk("t5 mark ready", 32'(tx_ready), 32'd0);
            tick();
        end
        check_idle("t5");
        chk("t5 end ready", 32'(tx_ready), 32'd1);

        // 6: async reset during DATA drives the line high immediately
        set_cfg(4, 8, 0, 0);
        start_frame("t6", 9'h0A5, 1'b0);
        repeat (9) tick();
        chk("t6 data tx", 32'(tx), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("t6 rst tx",    32'(tx),       32'd1);
        chk("t6 rst busy",  32'(tx_busy),  32'd0);
        chk("t6 rst ready", 32'(tx_ready), 32'd0);
        chk("t6 rst done",  32'(tx_done),  32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        chk("t6 rel ready", 32'(tx_ready), 32'd1);
        chk("t6 rel tx",    32'(tx),       32'd1);

        // 6b: illegal configurations block the handshake
        cfg_data_bits = 4'd4;
        tx_valid      = 1'b1;
        #1;
        chk("t6 db4 err",   32'(cfg_err),  32'd1);
        chk("t6 db4 ready", 32'(tx_ready), 32'd0);
        tick();
        tick();
        chk("t6 db4 busy",  32'(tx_busy),  32'd0);
        chk("t6 db4 tx",    32'(tx),       32'd1);
        cfg_data_bits = 4'd10;
        #1;
        chk("t6 db10 err", 32'(cfg_err), 32'd1);
        cfg_data_bits = 4'd9;
        cfg_parity    = 3'd5;
        #1;
        chk("t6 par5 err",   32'(cfg_err),  32'd1);
        chk("t6 par5 ready", 32'(tx_ready), 32'd0);
        tx_valid   = 1'b0;
        cfg_parity = 3'd0;
        #1;
        chk("t6 ok err",   32'(cfg_err),  32'd0);
        chk("t6 ok ready", 32'(tx_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
